cp0_unit: RTL and testbench

- Coprocessor-0 for the pipelined MIPS core. It sits downstream of the main controller and consumes its CP0WE, ExlClr and HWClr strobes for mtc0, mfc0 and eret.
- Holds SR, Cause, EPC and PRId, and latches the six hardware interrupt lines.
- Arbitrates interrupts against internal exceptions and raises IntReq to flush the pipeline to the handler.
- Instantiated in the M stage; EPC feeds the nPc_Sel=3 (eret) path.

---
 rtl/cp0_unit_pkg.sv | 56 +++++
 rtl/cp0_irq_arb.sv | 22 ++
 rtl/cp0_unit.sv | 139 +++++++++++++
 tb/tb_cp0_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, exception codes,
// the operating-mode encoding and small packing helpers.
package cp0_unit_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE_BIT    = 0;
   localparam int SR_EXL_BIT   = 1;
   localparam int SR_IM_LO     = 10;
   localparam int SR_IM_HI     = 15;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD_BIT = 31;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR.EXL is the mode bit: HANDLER is exactly EXL=1.
   typedef enum logic {
      MODE_NORMAL  = 1'b0,
      MODE_HANDLER = 1'b1
   } cp0_mode_e;

   function automatic logic [31:0] sr_pack(input logic [5:0] im, input logic exl, input logic ie);
      logic [31:0] v;
      v = '0;
      v[SR_IM_HI:SR_IM_LO] = im;
      v[SR_EXL_BIT]        = exl;
      v[SR_IE_BIT]         = ie;
      return v;
   endfunction

   function automatic logic [31:0] cause_pack(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] exc);
      logic [31:0] v;
      v = '0;
      v[CAUSE_BD_BIT]              = bd;
      v[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
      v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
      return v;
   endfunction

   // Word-aligned EPC for a victim; a delay-slot victim restarts at its branch.
   function automatic logic [29:0] victim_epc(input logic [29:0] vpc_word, input logic bd);
      return vpc_word - {29'd0, bd};
   endfunction

endpackage

// File: rtl/cp0_irq_arb.sv
// Combinational interrupt/exception arbitration; zero latency, no backpressure.
// A pending hardware interrupt always wins and reports ExcCode 0.
module cp0_irq_arb
   import cp0_unit_pkg::*;
#(
   parameter bit HANDLER_EXL_LOCK = 1'b1
) (
   input  logic [5:0] hw_int_i,
   input  logic [5:0] im_i,
   input  logic       ie_i,
   input  logic       exl_i,
   input  logic [4:0] exc_code_i,
   output logic       hw_req_o,
   output logic       ex_req_o,
   output logic [4:0] taken_code_o
);

   assign hw_req_o     = (|(hw_int_i & im_i)) & ie_i & ~exl_i;
   assign ex_req_o     = (exc_code_i != EXC_INT) & ~(exl_i & HANDLER_EXL_LOCK);
   assign taken_code_o = hw_req_o ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId state, exception entry and eret; reads are combinational,
// updates land on the next clock edge, and a taken exception squashes a same-cycle mtc0.
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter logic [31:0] PRID_VAL         = 32'h4255_4141,
   parameter bit          HANDLER_EXL_LOCK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        CP0WE,
   input  logic        ExlClr,
   input  logic        HWClr,
   input  logic [31:0] VPC,
   input  logic        BD,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   output logic        IntReq,
   output logic [31:0] EPC,
   output logic [31:0] DOut
);

   cp0_mode_e   mode_q;
   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_q, exc_d;
   logic [29:0] epc_q, epc_d;

   logic        exl;
   logic        hw_req;
   logic        ex_req;
   logic [4:0]  taken_code;
   logic        sr_wr;
   logic        unused_vpc;

   assign exl        = (mode_q == MODE_HANDLER);
   assign unused_vpc = ^VPC[1:0];

   cp0_irq_arb #(
      .HANDLER_EXL_LOCK(HANDLER_EXL_LOCK)
   ) u_arb (
      .hw_int_i    (HWInt),
      .im_i        (im_q),
      .ie_i        (ie_q),
      .exl_i       (exl),
      .exc_code_i  (ExcCodeIn),
      .hw_req_o    (hw_req),
      .ex_req_o    (ex_req),
      .taken_code_o(taken_code)
   );

   assign IntReq = hw_req | ex_req;
   assign sr_wr  = CP0WE & ~IntReq & (A2 == CP0_SR);

   always_comb begin
      im_d  = im_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      exc_d = exc_q;
      epc_d = epc_q;
      ip_d  = HWClr ? 6'd0 : HWInt;
      if (IntReq) begin
         exc_d = taken_code;
         bd_d  = BD;
         epc_d = victim_epc(VPC[31:2], BD);
      end else if (CP0WE) begin
         case (A2)
            CP0_SR: begin
               im_d = DIn[SR_IM_HI:SR_IM_LO];
               ie_d = DIn[SR_IE_BIT];
            end
            CP0_EPC: epc_d = DIn[31:2];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q  <= '0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= '0;
         exc_q <= '0;
         epc_q <= '0;
      end else begin
         im_q  <= im_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   // ExlClr beats a same-cycle mtc0 SR write for the EXL bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q <= MODE_NORMAL;
      end else begin
         case (mode_q)
            MODE_NORMAL: begin
               if (IntReq)
                  mode_q <= MODE_HANDLER;
               else if (sr_wr && DIn[SR_EXL_BIT] && !ExlClr)
                  mode_q <= MODE_HANDLER;
            end
            MODE_HANDLER: begin
               if (IntReq)
                  mode_q <= MODE_HANDLER;
               else if (ExlClr)
                  mode_q <= MODE_NORMAL;
               else if (sr_wr && !DIn[SR_EXL_BIT])
                  mode_q <= MODE_NORMAL;
            end
            default: mode_q <= MODE_NORMAL;
         endcase
      end
   end

   assign EPC = {epc_q, 2'b00};

   always_comb begin
      DOut = '0;
      case (A1)
         CP0_SR:    DOut = sr_pack(im_q, exl, ie_q);
         CP0_CAUSE: DOut = cause_pack(bd_q, ip_q, exc_q);
         CP0_EPC:   DOut = {epc_q, 2'b00};
         CP0_PRID:  DOut = PRID_VAL;
         default:   DOut = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus queues expected DOut/IntReq/EPC triples,
// a separate monitor pops and compares them when a sample is announced.
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] DIn;
   logic        CP0WE, ExlClr, HWClr;
   logic [31:0] VPC;
   logic        BD;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        IntReq;
   logic [31:0] EPC, DOut;

   typedef struct {
      string       name;
      logic [31:0] dout;
      logic        intreq;
      logic [31:0] epc;
   } exp_t;

   exp_t exp_q[$];
   event smp;
   int   total = 0;
   int   bad   = 0;

   cp0_unit #(
      .PRID_VAL        (32'h4255_4141),
      .HANDLER_EXL_LOCK(1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .A1       (A1),
      .A2       (A2),
      .DIn      (DIn),
      .CP0WE    (CP0WE),
      .ExlClr   (ExlClr),
      .HWClr    (HWClr),
      .VPC      (VPC),
      .BD       (BD),
      .ExcCodeIn(ExcCodeIn),
      .HWInt    (HWInt),
      .IntReq   (IntReq),
      .EPC      (EPC),
      .DOut     (DOut)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(smp);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (DOut !== e.dout || IntReq !== e.intreq || EPC !== e.epc) begin
               bad++;
               $display("FAIL %s: got DOut=%h IntReq=%b EPC=%h, want DOut=%h IntReq=%b EPC=%h",
                        e.name, DOut, IntReq, EPC, e.dout, e.intreq, e.epc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [4:0] a1, input logic [31:0] d,
                      input logic ir, input logic [31:0] ep);
      exp_t e;
      A1 = a1;
      #1;
      e.name   = nm;
      e.dout   = d;
      e.intreq = ir;
      e.epc    = ep;
      exp_q.push_back(e);
      -> smp;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; CP0WE = 1'b0; ExlClr = 1'b0; HWClr = 1'b0;
      VPC = '0; BD = 1'b0; ExcCodeIn = '0; HWInt = '0;
      #1 reset = 1'b0;
      #10;
      chk("rst_sr",    5'd12, 32'h0, 1'b0, 32'h0);
      chk("rst_cause", 5'd13, 32'h0, 1'b0, 32'h0);
      chk("rst_epc",   5'd14, 32'h0, 1'b0, 32'h0);
      chk("prid",      5'd15, 32'h4255_4141, 1'b0, 32'h0);
      chk("unmapped",  5'd3,  32'h0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      CP0WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
      tick;
      CP0WE = 1'b0;
      chk("sr_wr", 5'd12, 32'h0000_0401, 1'b0, 32'h0);
      HWInt = 6'b000001; VPC = 32'h0000_3010; BD = 1'b0;
      chk("hw_req", 5'd12, 32'h0000_0401, 1'b1, 32'h0);
      tick;
      chk("hw_cause", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3010);
      chk("hw_sr",    5'd12, 32'h0000_0403, 1'b0, 32'h0000_3010);

      ExlClr = 1'b1; HWClr = 1'b1;
      chk("eret_pre", 5'd12, 32'h0000_0403, 1'b0, 32'h0000_3010);
      tick;
      ExlClr = 1'b0; HWClr = 1'b0;
      chk("eret_sr",    5'd12, 32'h0000_0401, 1'b1, 32'h0000_3010);
      chk("eret_cause", 5'd13, 32'h0000_0000, 1'b1, 32'h0000_3010);
      tick;
      chk("retake_cause", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3010);
      HWInt = 6'b0; ExlClr = 1'b1;
      tick;
      ExlClr = 1'b0;
      chk("ret2_sr", 5'd12, 32'h0000_0401, 1'b0, 32'h0000_3010);

      ExcCodeIn = 5'd12; VPC = 32'h0000_3024; BD = 1'b1;
      chk("ov_req", 5'd13, 32'h0000_0000, 1'b1, 32'h0000_3010);
      tick;
      ExcCodeIn = 5'd0; BD = 1'b0;
      chk("ov_cause", 5'd13, 32'h8000_0030, 1'b0, 32'h0000_3020);
      chk("ov_epc",   5'd14, 32'h0000_3020, 1'b0, 32'h0000_3020);
      ExcCodeIn = 5'd5;
      chk("exl_lock", 5'd12, 32'h0000_0403, 1'b0, 32'h0000_3020);
      tick;
      ExcCodeIn = 5'd0;
      chk("lock_hold", 5'd13, 32'h8000_0030, 1'b0, 32'h0000_3020);
      ExlClr = 1'b1;
      tick;
      ExlClr = 1'b0;
      chk("ret3_sr", 5'd12, 32'h0000_0401, 1'b0, 32'h0000_3020);

      HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h0000_3040;
      CP0WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF;
      chk("both_req", 5'd12, 32'h0000_0401, 1'b1, 32'h0000_3020);
      tick;
      ExcCodeIn = 5'd0; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
      chk("both_cause", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3040);
      chk("both_epc",   5'd14, 32'h0000_3040, 1'b0, 32'h0000_3040);
      tick;
      CP0WE = 1'b0;
      chk("cause_ro", 5'd13, 32'h0000_0400, 1'b0, 32'h0000_3040);

      HWInt = 6'b0; CP0WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
      tick;
      CP0WE = 1'b0;
      chk("sr_exit",       5'd12, 32'h0000_FC01, 1'b0, 32'h0000_3040);
      chk("sr_exit_cause", 5'd13, 32'h0000_0000, 1'b0, 32'h0000_3040);

      CP0WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
      tick;
      DIn = 32'h0000_0803; ExlClr = 1'b1;
      chk("no_bypass", 5'd12, 32'h0000_FC03, 1'b0, 32'h0000_3040);
      tick;
      CP0WE = 1'b0; ExlClr = 1'b0;
      chk("exlclr_wins", 5'd12, 32'h0000_0801, 1'b0, 32'h0000_3040);

      CP0WE = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677;
      tick;
      CP0WE = 1'b0;
      chk("epc_wr", 5'd14, 32'h1234_5674, 1'b0, 32'h1234_5674);

      CP0WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
      tick;
      CP0WE = 1'b0;
      chk("pre_rst", 5'd12, 32'h0000_FC03, 1'b0, 32'h1234_5674);
      #5 reset = 1'b0;
      #1;
      chk("rst2_sr",    5'd12, 32'h0, 1'b0, 32'h0);
      chk("rst2_cause", 5'd13, 32'h0, 1'b0, 32'h0);
      chk("rst2_epc",   5'd14, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #5;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
